rcs_serial_16bit: RTL and testbench
===================================

# rcs_serial_16bit

Digit-serial 16-bit signed subtractor with valid/ready handshakes, the subtract-side counterpart to the 16-bit ripple-carry adder in the FIR datapath. It computes `diff = a - b - bin`, processing `DIGIT` bits per clock through one shared borrow chain. It reports the unsigned borrow-out and the signed overflow, and holds the result until the consumer accepts it. It trades latency for area in the FIR filter's coefficient-update and error-term paths.

## Interface
- `DIGIT`, default 4: bits processed per cycle. Legal values are 1, 2, 4, 8 and 16. Compute cycles are `N = 16/DIGIT`.
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous active-high reset.
- `in_valid`  input  1  operands present on `a`, `b` and `bin`.
- `in_ready`  output  1  block can accept operands. It is high only in state IDLE.
- `a`  input  16  signed minuend.
- `b`  input  16  signed subtrahend.
- `bin`  input  1  borrow-in, subtracted from the result.
- `out_valid`  output  1  result registers hold a valid result.
- `out_ready`  input  1  consumer accepts the result.
- `diff`  output  16  signed result, `a - b - bin` modulo 2^16.
- `borrow`  output  1  1 when, read as unsigned, `a < b + bin`.
- `ovf`  output  1  signed overflow: `a[15] != b[15]` and `diff[15] != a[15]`.

## Operation
- Operands are accepted on a rising edge where `in_valid && in_ready`. On that edge the block:
  - latches `a` and `~b` into shift registers;
  - sets the internal carry to `~bin`;
  - clears the digit counter `cnt`;
  - moves to CALC.
- State IDLE: `in_ready=1`, `out_valid=0`. Inputs are ignored unless `in_valid` is high.
- State CALC: each edge adds digit `cnt` of `a`, `~b` and the carry.
  - The DIGIT sum bits go into result bits `[cnt*DIGIT +: DIGIT]`.
  - The carry-out is stored for the next digit.
  - `cnt` increments.
  - On the edge with `cnt == N-1`, the block moves to DONE.
- State DONE: `out_valid=1`. The outputs are:
  - `borrow = ~carry`, using the final carry;
  - `ovf` computed from the latched `a[15]`, `b[15]` and `diff[15]`.
- On an edge with `out_ready=1` in DONE, the block returns to IDLE. There is no direct DONE-to-CALC path, so the next operand can be accepted at the earliest one cycle after the result handshake.
- While `out_ready=0`, `diff`, `borrow` and `ovf` stay stable and `out_valid` stays high.
- `in_valid` is ignored in CALC and DONE; `in_ready=0` there. Operand changes during CALC have no effect.
- `out_ready` is ignored outside DONE.
- Arithmetic is pure two's complement with wrap-around. No saturation.
- Reset at any time, including mid-CALC or in DONE, aborts the operation:
  - the state returns to IDLE;
  - `out_valid=0`, `in_ready=1`;
  - `diff=0`, `borrow=0`, `ovf=0`, `cnt=0`.
  - The partial result is discarded.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `diff=16'h0000`, `borrow=0`, `ovf=0`.
- Latency: the accept edge is E0, and `out_valid` rises after edge E0+N.
  - DIGIT=4: N=4.
  - DIGIT=1: N=16.
  - DIGIT=16: N=1, i.e. the result is valid after the edge following the accept edge.
- Throughput: at most one operation every N+2 cycles with `out_ready` tied high:
  - one cycle for the accept edge;
  - N CALC cycles;
  - one DONE cycle, which returns to IDLE on the next edge.
- All outputs are registered. No combinational path from any input to any output.
  - `in_ready` and `out_valid` are decoded from the state register only.
- The `diff` bits of digits not yet computed are don't-care while `out_valid=0`. The bench checks `diff` only while `out_valid=1`.

## Test plan
- Basic subtraction, DIGIT=4: `a=16'h0005`, `b=16'h0003`, `bin=0` -> `diff=16'h0002`, `borrow=0`, `ovf=0`. `out_valid` must rise exactly 4 edges after the accept edge.
- Borrow and wrap-around: `a=0`, `b=1`, `bin=0` -> `diff=16'hFFFF`, `borrow=1`, `ovf=0`.
- Borrow-in: `a=16'h0010`, `b=16'h0005`, `bin=1` -> `diff=16'h000A`, `borrow=0`.
- Signed overflow, two cases:
  - `a=16'h8000`, `b=1` -> `diff=16'h7FFF`, `ovf=1`, `borrow=0`.
  - `a=16'h7FFF`, `b=16'hFFFF` -> `diff=16'h8000`, `ovf=1`, `borrow=1`.
- Back-pressure: hold `out_ready=0` for 10 cycles in DONE while toggling `in_valid` and the operands. Required response:
  - outputs stable and `in_ready=0` throughout;
  - release `out_ready` -> IDLE next edge, then the next operands are accepted.
- Reset mid-operation: assert `rst` asynchronously at `cnt=2` -> immediately `in_ready=1`, `out_valid=0`, `diff=0`. A fresh operation after release gives the correct result. Repeat the DIGIT=1 and DIGIT=16 latency checks with 1000 random operands against a reference model.

Source files
------------

// File: rtl/rcs_serial_16bit.sv
// rcs_serial_16bit: digit-serial 16-bit signed subtractor computing a - b - bin with valid/ready handshakes
module rcs_serial_16bit #(
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        borrow,
  output logic        ovf
);
  localparam int N = 16 / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [15:0] a_sh, b_sh;
  logic carry, a15, nb15, last;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] sum;
  assign sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign last = cnt == CW'(N - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? CALC : IDLE) :
              state == CALC ? (last ? DONE : CALC) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      a15 <= 1'b0;
      nb15 <= 1'b0;
      diff <= '0;
      borrow <= 1'b0;
      ovf <= 1'b0;
    end else if (in_ready && in_valid) begin
      a_sh <= a;
      b_sh <= ~b;
      carry <= ~bin;
      cnt <= '0;
      a15 <= a[15];
      nb15 <= ~b[15];
    end else if (state == CALC) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      carry <= sum[DIGIT];
      cnt <= cnt + 1'b1;
      diff <= 16'({sum[DIGIT-1:0], diff} >> DIGIT);
      if (last) begin
        borrow <= ~sum[DIGIT];
        ovf <= (a15 == nb15) && (sum[DIGIT-1] != a15);
      end
    end
  end
endmodule

// File: tb/tb_rcs_serial_16bit.sv
// tb_rcs_serial_16bit: scoreboard bench running DIGIT=4, 1 and 16 subtractors on shared stimulus
module tb_rcs_serial_16bit;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, bin = 0;
  logic [15:0] a = 0, b = 0;
  logic [2:0] in_ready_v, out_valid_v, borrow_v, ovf_v;
  logic [2:0][15:0] diff_v;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [15:0] d; logic br; logic ov; int acc;} exp_t;
  exp_t q [3][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, got, want);
    end
  endtask
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    exp_t r;
    int u, s, sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    u = int'(x) - int'(y) - int'(bi);
    s = sx - sy - int'(bi);
    r.d = 16'(u);
    r.br = u < 0;
    r.ov = s < -32768 || s > 32767;
    r.acc = 0;
    return r;
  endfunction
  for (genvar i = 0; i < 3; i++) begin : g
    localparam int D = i == 0 ? 4 : i == 1 ? 1 : 16;
    logic pv = 0;
    rcs_serial_16bit #(.DIGIT(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[i]),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid_v[i]), .out_ready(out_ready),
      .diff(diff_v[i]), .borrow(borrow_v[i]), .ovf(ovf_v[i])
    );
    always @(negedge clk) begin
      if (rst) pv = 0;
      else begin
        if (out_valid_v[i] && !pv) begin
          if (q[i].size() == 0) chk("latency_unexpected_valid", i, 1, 0);
          else chk("latency", i, cyc - q[i][0].acc, 16 / D);
        end
        if (out_valid_v[i] && out_ready) begin
          if (q[i].size() == 0) chk("result_unexpected", i, 1, 0);
          else begin
            exp_t e;
            e = q[i].pop_front();
            chk("diff", i, diff_v[i], e.d);
            chk("borrow", i, borrow_v[i], e.br);
            chk("ovf", i, ovf_v[i], e.ov);
          end
        end
        pv = out_valid_v[i];
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (in_ready_v != 3'b111 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready_v != 3'b111) chk("wait_idle_timeout", 0, in_ready_v, 3'b111);
  endtask
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic bi);
    exp_t e;
    wait_idle();
    a = x;
    b = y;
    bin = bi;
    in_valid = 1;
    e = model(x, y, bi);
    e.acc = cyc + 1;
    for (int i = 0; i < 3; i++) q[i].push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    bin = 1'($urandom);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [15:0] sd;
    logic sb, so;
    int n;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", i, in_ready_v[i], 1);
      chk("rst_out_valid", i, out_valid_v[i], 0);
      chk("rst_diff", i, diff_v[i], 0);
      chk("rst_borrow", i, borrow_v[i], 0);
      chk("rst_ovf", i, ovf_v[i], 0);
    end
    rst = 0;
    issue(16'h0005, 16'h0003, 0);
    issue(16'h0000, 16'h0001, 0);
    issue(16'h0010, 16'h0005, 1);
    issue(16'h8000, 16'h0001, 0);
    issue(16'h7FFF, 16'hFFFF, 0);
    issue(16'h8000, 16'h0000, 1);
    issue(16'hFFFF, 16'hFFFF, 1);
    wait_idle();
    out_ready = 0;
    issue(16'h1234, 16'h4321, 1);
    n = 0;
    while (out_valid_v != 3'b111 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_all_valid", 0, out_valid_v, 3'b111);
    sd = diff_v[0];
    sb = borrow_v[0];
    so = ovf_v[0];
    repeat (10) begin
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom);
      @(posedge clk);
      #1;
      chk("bp_diff_stable", 0, diff_v[0], sd);
      chk("bp_borrow_stable", 0, borrow_v[0], sb);
      chk("bp_ovf_stable", 0, ovf_v[0], so);
      chk("bp_in_ready_low", 0, in_ready_v, 3'b000);
      chk("bp_out_valid_high", 0, out_valid_v, 3'b111);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", 0, in_ready_v, 3'b111);
    issue(16'hA5A5, 16'h5A5A, 0);
    issue(16'h0001, 16'h8000, 0);
    wait_idle();
    issue(16'h3333, 16'h1111, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_in_ready", i, in_ready_v[i], 1);
      chk("midrst_out_valid", i, out_valid_v[i], 0);
      chk("midrst_diff", i, diff_v[i], 0);
      chk("midrst_borrow", i, borrow_v[i], 0);
      q[i].delete();
    end
    @(posedge clk);
    #1;
    rst = 0;
    issue(16'h0100, 16'h0001, 1);
    repeat (1000) issue(16'($urandom), 16'($urandom), 1'($urandom));
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 0, q[0].size() + q[1].size() + q[2].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
